// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared constants, exception codes and FSM encoding for pipe_ctrl
// Contents: bus width, stall/reset levels, exception type codes, FSM state
// enum and the stage-mask helper used by the requestor decode.
package pipe_ctrl_pkg;

  localparam int REG_BUS = 32;

  localparam logic STOP       = 1'b1;
  localparam logic NO_STOP    = 1'b0;
  localparam logic RST_ENABLE = 1'b0;

  localparam logic [31:0] EXC_NONE         = 32'h0;
  localparam logic [31:0] EXC_INT          = 32'h1;
  localparam logic [31:0] EXC_SYSCALL      = 32'h8;
  localparam logic [31:0] EXC_INST_INVALID = 32'ha;
  localparam logic [31:0] EXC_TRAP         = 32'hc;
  localparam logic [31:0] EXC_OV           = 32'hd;
  localparam logic [31:0] EXC_ERET         = 32'he;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // Bits [top:0] set; freezing a stage also freezes every stage upstream of it.
  function automatic logic [15:0] low_mask(input logic [3:0] top);
    logic [16:0] m;
    m = (17'd1 << ({1'b0, top} + 5'd1)) - 17'd1;
    return m[15:0];
  endfunction

endpackage

// File: rtl/stall_watchdog.sv
// rtl/stall_watchdog.sv - consecutive-stall watchdog with sticky timeout flag
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   stalled     1 in any cycle where some pipeline stage is stalled
//   wd_clear    clears the sticky flag and the run counter (wins over a new timeout)
//   timeout     sticky flag, set once WD_LIMIT consecutive stalled cycles are seen
module stall_watchdog #(
  parameter int WD_LIMIT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stalled,
  input  logic wd_clear,
  output logic timeout
);

  localparam int CW = (WD_LIMIT > 1) ? $clog2(WD_LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(WD_LIMIT - 1);

  logic [CW-1:0] wcnt;

  // wcnt parks at LAST while the stall persists, so the flag is set on the
  // WD_LIMIT-th consecutive stalled edge and the counter never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt    <= '0;
      timeout <= 1'b0;
    end else if (wd_clear) begin
      wcnt    <= '0;
      timeout <= 1'b0;
    end else begin
      if (!stalled) begin
        wcnt <= '0;
      end else if (wcnt != LAST) begin
        wcnt <= wcnt + CW'(1);
      end
      if (stalled && (wcnt == LAST)) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush controller with flush sequencer, watchdog and perf counter
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   stallreq_i        per-requestor stall request (active at STOP)
//   excep_type_i      exception type from MEM stage, 0 = none
//   cp0_epc_i         return address used for ERET
//   wd_clear_i        clears the sticky watchdog flag
//   stall_o           per-stage stall, bit 0 is the PC stage
//   flush_o           pipeline flush
//   excep_vector_o    new PC, valid while flush_o is high
//   stall_timeout_o   sticky watchdog flag
//   stall_cycles_o    saturating count of stalled cycles
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int                  N_STAGES     = 6,
  parameter int                  N_REQ        = 3,
  parameter logic [4*N_REQ-1:0]  REQ_STAGE    = {4'd4, 4'd3, 4'd2},
  parameter int                  DW           = REG_BUS,
  parameter int                  FLUSH_CYCLES = 1,
  parameter logic [DW-1:0]       INT_VEC      = 'h20,
  parameter logic [DW-1:0]       GEN_VEC      = 'h40,
  parameter int                  WD_LIMIT     = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    stallreq_i,
  input  logic [31:0]         excep_type_i,
  input  logic [DW-1:0]       cp0_epc_i,
  input  logic                wd_clear_i,
  output logic [N_STAGES-1:0] stall_o,
  output logic                flush_o,
  output logic [DW-1:0]       excep_vector_o,
  output logic                stall_timeout_o,
  output logic [31:0]         stall_cycles_o
);

  state_e        state_q, state_d;
  logic [3:0]    fcnt_q, fcnt_d;
  logic [DW-1:0] vec_q, vec_d;
  logic [DW-1:0] dec_vec;
  logic          excep_valid;
  logic [15:0]   req_bits;
  logic [N_STAGES-1:0] req_mask;
  logic [31:0]   perf_q;
  logic          stalled;

  always_comb begin
    req_bits = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (stallreq_i[k] == STOP) begin
        req_bits = req_bits | low_mask(REQ_STAGE[4*k +: 4]);
      end
    end
    req_mask = req_bits[N_STAGES-1:0];
  end

  assign excep_valid = (excep_type_i != EXC_NONE);

  always_comb begin
    if (excep_type_i == EXC_INT) begin
      dec_vec = INT_VEC;
    end else if (excep_type_i == EXC_ERET) begin
      dec_vec = cp0_epc_i;
    end else begin
      dec_vec = GEN_VEC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      fcnt_q  <= '0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      vec_q   <= vec_d;
    end
  end

  // The vector is captured on the exception edge so a later change of
  // cp0_epc_i cannot disturb the remaining flush cycles.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    vec_d   = vec_q;
    case (state_q)
      ST_IDLE: begin
        if (excep_valid) begin
          vec_d = dec_vec;
          if (FLUSH_CYCLES > 1) begin
            state_d = ST_FLUSH;
            fcnt_d  = 4'(FLUSH_CYCLES - 1);
          end
        end
      end
      ST_FLUSH: begin
        fcnt_d = fcnt_q - 4'd1;
        if (fcnt_q == 4'd1) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are gated with rst_n so the combinational paths are quiet in reset.
  always_comb begin
    flush_o        = 1'b0;
    excep_vector_o = '0;
    stall_o        = '0;
    if (rst_n) begin
      if (state_q == ST_FLUSH) begin
        flush_o        = 1'b1;
        excep_vector_o = vec_q;
      end else if (excep_valid) begin
        flush_o        = 1'b1;
        excep_vector_o = dec_vec;
      end else begin
        stall_o = req_mask;
      end
    end
  end

  assign stalled = |stall_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else if (stalled && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign stall_cycles_o = perf_q;

  stall_watchdog #(
    .WD_LIMIT (WD_LIMIT)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .stalled  (stalled),
    .wd_clear (wd_clear_i),
    .timeout  (stall_timeout_o)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl, three flush lengths side by side
module tb_pipe_ctrl;

  localparam int NI = 3;
  localparam int WDL = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  stallreq;
  logic [31:0] excep_type;
  logic [31:0] cp0_epc;
  logic        wd_clear;

  logic [5:0]  stall_w [NI];
  logic        flush_w [NI];
  logic [31:0] vec_w   [NI];
  logic        to_w    [NI];
  logic [31:0] perf_w  [NI];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    pipe_ctrl #(
      .FLUSH_CYCLES ((g == 0) ? 1 : (g == 1) ? 3 : 4),
      .WD_LIMIT     (WDL)
    ) u_dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .stallreq_i      (stallreq),
      .excep_type_i    (excep_type),
      .cp0_epc_i       (cp0_epc),
      .wd_clear_i      (wd_clear),
      .stall_o         (stall_w[g]),
      .flush_o         (flush_w[g]),
      .excep_vector_o  (vec_w[g]),
      .stall_timeout_o (to_w[g]),
      .stall_cycles_o  (perf_w[g])
    );
  end

  // Reference model: remaining flush cycles, held vector, consecutive stall run.
  int          fleft [NI];
  logic [31:0] vhold [NI];
  int          run   [NI];
  logic        flag  [NI];
  logic [31:0] perf  [NI];

  function automatic int fc_of(int g);
    return (g == 0) ? 1 : (g == 1) ? 3 : 4;
  endfunction

  function automatic logic [31:0] dec(logic [31:0] t, logic [31:0] epc);
    if (t == 32'h1) return 32'h20;
    if (t == 32'he) return epc;
    return 32'h40;
  endfunction

  function automatic logic [5:0] req_to_mask(logic [2:0] r);
    int top = -1;
    // Requestor k freezes stages 0..k+2; the union is set by the highest active one.
    for (int k = 0; k < 3; k++) if (r[k]) top = k + 2;
    return (top < 0) ? 6'd0 : 6'((1 << (top + 1)) - 1);
  endfunction

  function automatic logic m_flush(int g);
    return rst_n && (fleft[g] > 0 || excep_type != 0);
  endfunction

  function automatic logic [31:0] m_vec(int g);
    if (!rst_n) return 32'h0;
    if (fleft[g] > 0) return vhold[g];
    if (excep_type != 0) return dec(excep_type, cp0_epc);
    return 32'h0;
  endfunction

  function automatic logic [5:0] m_stall(int g);
    if (!rst_n || m_flush(g)) return 6'd0;
    return req_to_mask(stallreq);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < NI; g++) begin
        fleft[g] = 0; vhold[g] = 0; run[g] = 0; flag[g] = 0; perf[g] = 0;
      end
    end else begin
      for (int g = 0; g < NI; g++) begin
        logic st;
        st = (m_stall(g) != 0);
        if (fleft[g] > 0) fleft[g]--;
        else if (excep_type != 0) begin
          fleft[g] = fc_of(g) - 1;
          vhold[g] = dec(excep_type, cp0_epc);
        end
        if (wd_clear) begin
          run[g] = 0; flag[g] = 0;
        end else if (st) begin
          run[g]++;
          if (run[g] >= WDL) flag[g] = 1;
        end else run[g] = 0;
        if (st && perf[g] != 32'hFFFF_FFFF) perf[g]++;
      end
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      check($sformatf("stall[%0d]", g), 32'(stall_w[g]), 32'(m_stall(g)));
      check($sformatf("flush[%0d]", g), 32'(flush_w[g]), 32'(m_flush(g)));
      check($sformatf("vector[%0d]", g), vec_w[g], m_vec(g));
      check($sformatf("timeout[%0d]", g), 32'(to_w[g]), 32'(flag[g]));
      check($sformatf("perf[%0d]", g), perf_w[g], perf[g]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stallreq = '0; excep_type = '0; cp0_epc = '0; wd_clear = 1'b0;
    tick(); tick();
    stallreq = 3'b111; excep_type = 32'h1;
    sample();
    check("reset_stall", 32'(stall_w[0]), 32'h0);
    check("reset_flush", 32'(flush_w[0]), 32'h0);
    check("reset_vector", vec_w[0], 32'h0);
    tick();
    stallreq = '0; excep_type = '0; rst_n = 1'b1;
    sample();
    check("reset_perf", perf_w[0], 32'h0);
    check("reset_timeout", 32'(to_w[0]), 32'h0);

    // Stall masks; three stalled cycles then a gap must not fire the watchdog.
    tick(); stallreq = 3'b010; sample(); check("mask_010", 32'(stall_w[0]), 32'h0f);
    tick(); stallreq = 3'b001; sample(); check("mask_001", 32'(stall_w[0]), 32'h07);
    tick(); stallreq = 3'b111; sample(); check("mask_111", 32'(stall_w[0]), 32'h1f);
    tick(); stallreq = 3'b000; sample(); check("mask_drop", 32'(stall_w[0]), 32'h00);
    tick(); sample(); check("wd_gap_nofire", 32'(to_w[0]), 32'h0);

    // Single-cycle flush beats a stall.
    tick(); stallreq = 3'b010; excep_type = 32'h8;
    sample();
    check("sflush_flush", 32'(flush_w[0]), 32'h1);
    check("sflush_vec", vec_w[0], 32'h40);
    check("sflush_stall", 32'(stall_w[0]), 32'h0);
    tick(); excep_type = 32'h0;
    sample();
    check("sflush_after", 32'(flush_w[0]), 32'h0);
    check("sflush_stall_back", 32'(stall_w[0]), 32'h0f);
    tick(); stallreq = 3'b000;
    repeat (4) tick();

    // ERET with a three-cycle flush; a second exception in cycle 2 is ignored.
    cp0_epc = 32'h1234; excep_type = 32'he;
    sample(); check("eret_c1_flush", 32'(flush_w[1]), 32'h1); check("eret_c1_vec", vec_w[1], 32'h1234);
    tick(); cp0_epc = 32'h0; excep_type = 32'h1;
    sample(); check("eret_c2_flush", 32'(flush_w[1]), 32'h1); check("eret_c2_vec", vec_w[1], 32'h1234);
    tick(); excep_type = 32'h0;
    sample(); check("eret_c3_flush", 32'(flush_w[1]), 32'h1); check("eret_c3_vec", vec_w[1], 32'h1234);
    tick();
    sample(); check("eret_c4_flush", 32'(flush_w[1]), 32'h0); check("eret_c4_vec", vec_w[1], 32'h0);
    repeat (4) tick();

    // Reset in the second cycle of a four-cycle flush.
    stallreq = 3'b010; excep_type = 32'h8;
    sample(); check("rflush_c1", 32'(flush_w[2]), 32'h1); check("rflush_c1_vec", vec_w[2], 32'h40);
    tick(); excep_type = 32'h0;
    #2 rst_n = 1'b0;
    sample();
    check("rflush_flush", 32'(flush_w[2]), 32'h0);
    check("rflush_vec", vec_w[2], 32'h0);
    check("rflush_stall", 32'(stall_w[2]), 32'h0);
    tick(); rst_n = 1'b1;
    sample(); check("rflush_rel_flush", 32'(flush_w[2]), 32'h0); check("rflush_rel_stall", 32'(stall_w[2]), 32'h0f);
    tick(); sample(); check("rflush_rel2_flush", 32'(flush_w[2]), 32'h0);
    tick(); stallreq = 3'b000;
    tick();

    // Watchdog: fires after the fourth stalled edge, sticky, cleared by wd_clear.
    stallreq = 3'b001;
    tick(); tick(); tick();
    sample(); check("wd_before", 32'(to_w[0]), 32'h0);
    tick();
    sample(); check("wd_fire", 32'(to_w[0]), 32'h1);
    tick(); stallreq = 3'b000;
    sample(); check("wd_sticky", 32'(to_w[0]), 32'h1);
    tick(); wd_clear = 1'b1;
    tick(); wd_clear = 1'b0;
    sample(); check("wd_cleared", 32'(to_w[0]), 32'h0);

    // Perf counter: 10 stalled cycles interleaved with 5 flush cycles.
    tick(); rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (i % 3 == 2) begin
        excep_type = 32'h8; stallreq = 3'b111;
      end else begin
        excep_type = 32'h0; stallreq = 3'($urandom_range(1, 7));
      end
      tick();
    end
    excep_type = 32'h0; stallreq = 3'b000;
    sample(); check("perf_ten", perf_w[0], 32'd10);

    // Saturation at all-ones.
    tick();
    force g_dut[0].u_dut.perf_q = 32'hFFFF_FFFE;
    perf[0] = 32'hFFFF_FFFE;
    stallreq = 3'b001;
    #1 release g_dut[0].u_dut.perf_q;
    tick(); tick(); tick();
    stallreq = 3'b000;
    sample(); check("perf_sat", perf_w[0], 32'hFFFF_FFFF);

    // Randomised traffic against the model.
    for (int i = 0; i < 800; i++) begin
      int r;
      tick();
      rst_n    = ($urandom_range(0, 99) != 0);
      stallreq = ($urandom_range(0, 2) == 0) ? 3'b000 : 3'($urandom);
      r = $urandom_range(0, 9);
      case (r)
        6: excep_type = 32'h1;
        7: excep_type = 32'he;
        8: case ($urandom_range(0, 3))
             0: excep_type = 32'h8;
             1: excep_type = 32'ha;
             2: excep_type = 32'hc;
             default: excep_type = 32'hd;
           endcase
        9: excep_type = $urandom;
        default: excep_type = 32'h0;
      endcase
      cp0_epc  = $urandom;
      wd_clear = ($urandom_range(0, 19) == 0);
    end
    tick();
    sample();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Parametrised successor of the pipeline stall/flush controller.
- Generalises to N_STAGES pipeline stages and N_REQ stall requestors, each bound to a stage position by parameter.
- Adds a multi-cycle flush sequencer that latches the exception vector, plus a stall watchdog and a saturating stall-cycle performance counter.
- Sits beside the pipeline registers and drives their stall and flush inputs; the PC register takes excep_vector_o.

Parameters:
- N_STAGES, 6, number of pipeline register stages; stall_o bit 0 is the PC stage.
- N_REQ, 3, number of stall requestors.
- REQ_STAGE, {4'd4,4'd3,4'd2}, packed 4-bit fields; field k is the highest stage frozen by requestor k (k=0 in the LSBs). Every field must be < N_STAGES.
- DW, 32, data/address width (`RegBus).
- FLUSH_CYCLES, 1, cycles flush_o stays high per exception. Range 1..15.
- INT_VEC, 32'h20, vector for exception type 1 (interrupt).
- GEN_VEC, 32'h40, vector for all other non-ERET exceptions.
- WD_LIMIT, 1024, consecutive stall cycles before the watchdog fires. Must be >= 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, active-low.
- stallreq_i  in  N_REQ  stall request per requestor; active level is `Stop.
- excep_type_i  in  32  exception type from the MEM stage; 0 means no exception.
- cp0_epc_i  in  DW  EPC from CP0.
- wd_clear_i  in  1  clears the sticky watchdog flag.
- stall_o  out  N_STAGES  per-stage stall.
- flush_o  out  1  pipeline flush.
- excep_vector_o  out  DW  new PC, valid whenever flush_o=1.
- stall_timeout_o  out  1  sticky watchdog flag.
- stall_cycles_o  out  32  saturating count of cycles with any stall_o bit set.

Behaviour:
- Reset: one clock domain, clk; asynchronous, active-low reset, rst_n. While rst_n is low all outputs are 0 and the FSM is IDLE. Reset asserted mid-FLUSH aborts the sequence; there is no residual flush after release.
- Stall mask:
  - For each active requestor k, bits [REQ_STAGE[k]:0] of stall_o are set.
  - stall_o is the OR over all active requestors, combinational, same cycle.
  - With defaults: req1 alone gives 001111, req0 alone gives 000111.
- Exception decode, combinational from the type:
  - 32'h1 gives INT_VEC.
  - 32'he (ERET) gives cp0_epc_i.
  - Any other nonzero value gives GEN_VEC.
- FSM states: IDLE, FLUSH.
  - IDLE, excep_type_i != 0: flush_o=1 in the same cycle and excep_vector_o = decoded vector (combinational). The vector is latched into vec_q.
    - FLUSH_CYCLES=1: stay IDLE.
    - FLUSH_CYCLES>1: go to FLUSH with fcnt = FLUSH_CYCLES-1.
  - FLUSH: flush_o=1 and excep_vector_o = vec_q. fcnt decrements each cycle; at fcnt==1 return to IDLE. excep_type_i is ignored in FLUSH (the pipeline is being squashed).
  - IDLE, no exception: flush_o=0, excep_vector_o=0.
- Priority: in any cycle where flush_o=1, stall_o is forced to 0. Exception beats stall.
- Watchdog (sub-module):
  - wcnt increments in each cycle where stall_o != 0; it clears to 0 on any cycle with stall_o == 0.
  - When wcnt reaches WD_LIMIT-1 while still stalled, stall_timeout_o is set on the next edge and stays set.
  - wd_clear_i clears the flag and wcnt. If a new timeout and the clear happen in the same cycle, the clear wins.
  - wcnt saturates at WD_LIMIT-1.
- Perf counter: stall_cycles_o increments on each cycle with stall_o != 0 and saturates at 32'hFFFF_FFFF. It is reset only by rst_n.

Decomposition:
- Exception type codes (EXC_INT=1, EXC_SYSCALL=8, EXC_INST_INVALID=a, EXC_TRAP=c, EXC_OV=d, EXC_ERET=e) and the FSM state encodings go in the shared defines file next to `RegBus, `Stop and `RstEnable.
- One sub-module, stall_watchdog: it holds the wcnt counter and the sticky flag, parametrised by WD_LIMIT.
- The mask generation, FSM, vector latch and perf counter stay in pipe_ctrl.

Test Plan:
- Masks: defaults, stallreq_i=3'b010 gives stall_o=6'b001111; 3'b001 gives 6'b000111; 3'b111 gives 6'b011111. Drop all requests and stall_o=0 in the same cycle.
- Single-cycle flush: FLUSH_CYCLES=1, excep_type_i=32'h8 for one cycle while stallreq_i=3'b010. Expect flush_o=1, excep_vector_o=32'h40 and stall_o=0 that cycle, then flush_o=0.
- Multi-cycle ERET: FLUSH_CYCLES=3, cp0_epc_i=32'h1234, excep_type_i=32'he for one cycle.
  - Expect flush_o high for exactly 3 cycles with excep_vector_o=32'h1234 throughout, even though cp0_epc_i changes to 32'h0 after cycle 1.
  - A second exception (32'h1) arriving in cycle 2 is ignored.
- Reset mid-flush: FLUSH_CYCLES=4, pull rst_n low in the second flush cycle. flush_o, excep_vector_o and stall_o go to 0 immediately; after release they stay 0 with no exception present.
- Watchdog: WD_LIMIT=4, hold stallreq_i=3'b001.
  - stall_timeout_o rises after the 4th stalled edge and stays high when the stall drops.
  - Pulse wd_clear_i and the flag returns to 0.
  - A 3-cycle stall followed by a 1-cycle gap never fires.
- Perf counter: 10 stalled cycles interleaved with 5 flush cycles (stall masked) give stall_cycles_o=10. Force the counter to 32'hFFFF_FFFE, stall 3 cycles, and expect it to hold at 32'hFFFF_FFFF.
